mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/rr_arb2.sv | 41 ++++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: width defaults, requester IDs and
// the lock-state encoding used when ARB_LOCK_EN is defined.
package osecpu_mem_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 32;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. grant is one-hot (bit 0 = A, bit 1 = B).
// The priority pointer always moves to the requester that did not win.
// force_b masks A entirely and hands B the grant whenever B asks.
module rr_arb2
    import osecpu_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       force_b,
    output logic [1:0] grant,
    output req_id_t    pointer
);

    // Grant selection: single requester wins outright, contention follows the pointer
    always_comb begin
        grant = 2'b00;
        if (force_b) begin
            grant[1] = req[1];
        end else begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (pointer == REQ_A) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Pointer update: favour the loser of every grant
    always_ff @(posedge clk) begin
        if (reset) begin
            pointer <= REQ_A;
        end else if (grant[0]) begin
            pointer <= REQ_B;
        end else if (grant[1]) begin
            pointer <= REQ_A;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port word memory between requester A (fetch) and
// requester B (load/store). Winner is registered into a one-stage access
// pipe; read data comes back two cycles after the ack.
// Optional macro ARB_LOCK_EN adds b_lock and a LOCKED state that keeps A
// out until B issues an access with b_lock low (atomic read-modify-write).
module mem_arbiter
    import osecpu_mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    input  logic          b_we,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_rvalid,
`ifdef ARB_LOCK_EN
    input  logic          b_lock,
`endif
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic [1:0] req_vec;
    logic [1:0] grant;
    logic       force_b;
    req_id_t    pointer;
    logic       mem_we_q;
    req_id_t    owner_q;
    logic       rd_pend_q;

    // No request is visible while reset is held, so no ack can be issued
    assign req_vec = {b_req, a_req} & {2{~reset}};

`ifdef ARB_LOCK_EN
    // state    | meaning
    // UNLOCKED | normal round-robin between A and B
    // LOCKED   | B owns the memory; A is never granted
    lock_state_t lock_state;

    // Lock FSM: every B grant re-evaluates the lock from b_lock
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state <= UNLOCKED;
        end else if (grant[1]) begin
            lock_state <= b_lock ? LOCKED : UNLOCKED;
        end
    end

    assign force_b = (lock_state == LOCKED);
`else
    assign force_b = 1'b0;
`endif

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req     (req_vec),
        .force_b (force_b),
        .grant   (grant),
        .pointer (pointer)
    );

    assign a_ack = grant[0];
    assign b_ack = grant[1];

    // Reset during the access cycle must stop the write from reaching memory,
    // so the registered enable is also masked by reset itself.
    assign mem_we = mem_we_q & ~reset;

    // Access pipe: latch the winning command; idle cycles keep the address
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we_q  <= 1'b0;
            mem_wdata <= '0;
            owner_q   <= REQ_A;
            rd_pend_q <= 1'b0;
        end else if (grant[0]) begin
            mem_addr  <= a_addr;
            mem_we_q  <= a_we;
            mem_wdata <= a_wdata;
            owner_q   <= REQ_A;
            rd_pend_q <= ~a_we;
        end else if (grant[1]) begin
            mem_addr  <= b_addr;
            mem_we_q  <= b_we;
            mem_wdata <= b_wdata;
            owner_q   <= REQ_B;
            rd_pend_q <= ~b_we;
        end else begin
            mem_we_q  <= 1'b0;
            rd_pend_q <= 1'b0;
        end
    end

    // Read return: capture memory data at the end of the access cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata    <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= rd_pend_q & (owner_q == REQ_A);
            b_rvalid <= rd_pend_q & (owner_q == REQ_B);
            if (rd_pend_q) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural word memory. The
// stimulus process pushes expected read responses; a monitor pops them
// whenever a_rvalid or b_rvalid is seen.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, a_rvalid, b_ack, b_rvalid;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;

    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;
    logic [DW-1:0] mem [65536];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          owner;
        logic [DW-1:0] data;
    } sb_t;
    sb_t sb[$];

    typedef struct packed {
        logic          a_req;
        logic [AW-1:0] a_addr;
        logic          a_we;
        logic [DW-1:0] a_wdata;
        logic          b_req;
        logic [AW-1:0] b_addr;
        logic          b_we;
        logic [DW-1:0] b_wdata;
        logic          b_lock;
        logic [1:0]    exp_ack;
        logic [DW-1:0] exp_rd;
    } vec_t;

    logic          exp_we_nxt;
    logic [AW-1:0] exp_addr_nxt;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_we      (a_we),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rvalid  (a_rvalid),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_we      (b_we),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rvalid  (b_rvalid),
`ifdef ARB_LOCK_EN
        .b_lock    (b_lock),
`endif
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding read
    always @(negedge clk) begin
        if (!reset && (a_rvalid || b_rvalid)) begin
            chk("rvalid_onehot", {31'd0, a_rvalid & b_rvalid}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {31'd0, b_rvalid}, 32'hFFFF_FFFF);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("rvalid_owner", {31'd0, b_rvalid}, {31'd0, e.owner});
                chk("rdata", rdata, e.data);
            end
        end
    end

    function automatic vec_t v(input logic ar, input logic [AW-1:0] aa, input logic aw,
                               input logic [DW-1:0] ad, input logic br, input logic [AW-1:0] ba,
                               input logic bw, input logic [DW-1:0] bd, input logic bl,
                               input logic [1:0] ea, input logic [DW-1:0] er);
        vec_t t;
        t = '{ar, aa, aw, ad, br, ba, bw, bd, bl, ea, er};
        return t;
    endfunction

    function automatic vec_t idle();
        return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    endfunction

    task automatic apply(input vec_t t);
        @(negedge clk);
        chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we_nxt});
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, exp_addr_nxt});
        a_req = t.a_req; a_addr = t.a_addr; a_we = t.a_we; a_wdata = t.a_wdata;
        b_req = t.b_req; b_addr = t.b_addr; b_we = t.b_we; b_wdata = t.b_wdata;
        b_lock = t.b_lock;
        #1;
        chk("ack", {30'd0, b_ack, a_ack}, {30'd0, t.exp_ack});
        exp_we_nxt = 1'b0;
        if (t.exp_ack == 2'b01) begin
            exp_addr_nxt = t.a_addr;
            exp_we_nxt   = t.a_we;
            if (!t.a_we) sb.push_back('{1'b0, t.exp_rd});
        end else if (t.exp_ack == 2'b10) begin
            exp_addr_nxt = t.b_addr;
            exp_we_nxt   = t.b_we;
            if (!t.b_we) sb.push_back('{1'b1, t.exp_rd});
        end
    endtask

    task automatic do_reset(input bit preload);
        @(negedge clk);
        reset = 1'b1;
        a_req = 0; b_req = 0;
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                bd_we   = 1'b1;
                bd_addr = 16'(i);
                bd_data = (i == 5) ? 32'hDEAD_BEEF : (i == 7) ? 32'h0000_0001 : 32'h1000_0000 + 32'(i);
                @(negedge clk);
            end
            bd_we = 1'b0;
        end
        @(negedge clk);
        a_req = 1; b_req = 1;
        #1;
        chk("reset_ack", {30'd0, b_ack, a_ack}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        a_req = 0; b_req = 0;
        chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_rvalid", {30'd0, b_rvalid, a_rvalid}, 32'd0);
        exp_we_nxt   = 1'b0;
        exp_addr_nxt = '0;
    endtask

    initial begin
        reset = 1'b1;
        a_req = 0; a_addr = 0; a_we = 0; a_wdata = 0;
        b_req = 0; b_addr = 0; b_we = 0; b_wdata = 0; b_lock = 0;
        bd_we = 0; bd_addr = 0; bd_data = 0;
        exp_we_nxt = 0; exp_addr_nxt = 0;

        do_reset(1'b1);

        // single read of word 5 by A
        apply(v(1, 5, 0, 0, 0, 0, 0, 0, 0, 2'b01, 32'hDEAD_BEEF));
        repeat (3) apply(idle());

        // B write then read-back of addr 3 on consecutive cycles
        apply(v(0, 0, 0, 0, 1, 3, 1, 32'h1234_5678, 0, 2'b10, 0));
        apply(v(0, 0, 0, 0, 1, 3, 0, 0, 0, 2'b10, 32'h1234_5678));
        repeat (3) apply(idle());

        // starvation: B streams reads, A arrives and is served at once
        apply(v(0, 0, 0, 0, 1, 9, 0, 0, 0, 2'b10, 32'h1000_0009));
        apply(v(1, 8, 0, 0, 1, 9, 0, 0, 0, 2'b01, 32'h1000_0008));
        apply(v(0, 0, 0, 0, 1, 9, 0, 0, 0, 2'b10, 32'h1000_0009));
        repeat (3) apply(idle());

        // reset during the access cycle of a write
        apply(v(1, 7, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 2'b01, 0));
        @(negedge clk);
        chk("midwrite_we_before", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        a_req = 1; a_addr = 7; a_we = 1; a_wdata = 32'hFFFF_FFFF;
        #1;
        chk("midwrite_ack", {31'd0, a_ack}, 32'd0);
        chk("midwrite_we_forced", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        a_req = 0;
        chk("midwrite_mem7", mem[7], 32'h0000_0001);
        chk("midwrite_mem_we", {31'd0, mem_we}, 32'd0);
        chk("midwrite_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("midwrite_mem_wdata", mem_wdata, 32'd0);
        chk("midwrite_rdata", rdata, 32'd0);
        chk("midwrite_rvalid", {30'd0, b_rvalid, a_rvalid}, 32'd0);
        exp_we_nxt   = 1'b0;
        exp_addr_nxt = '0;

        // contention straight after reset: A first, then strict alternation
        apply(v(1, 10, 0, 0, 1, 11, 0, 0, 0, 2'b01, 32'h1000_000A));
        apply(v(1, 12, 0, 0, 1, 11, 0, 0, 0, 2'b10, 32'h1000_000B));
        apply(v(1, 12, 0, 0, 1, 13, 0, 0, 0, 2'b01, 32'h1000_000C));
        apply(v(1, 14, 0, 0, 1, 13, 0, 0, 0, 2'b10, 32'h1000_000D));
        apply(v(1, 14, 0, 0, 0, 0, 0, 0, 0, 2'b01, 32'h1000_000E));
        repeat (3) apply(idle());

`ifdef ARB_LOCK_EN
        // locked read-modify-write by B keeps A waiting
        apply(v(0, 0, 0, 0, 1, 4, 0, 0, 1, 2'b10, 32'h1000_0004));
        repeat (4) apply(v(1, 2, 0, 0, 1, 4, 0, 0, 1, 2'b10, 32'h1000_0004));
        apply(v(1, 2, 0, 0, 1, 6, 1, 32'h55AA_55AA, 0, 2'b10, 0));
        apply(v(1, 2, 0, 0, 1, 6, 0, 0, 0, 2'b01, 32'h1000_0002));
        apply(v(0, 0, 0, 0, 1, 6, 0, 0, 0, 2'b10, 32'h55AA_55AA));
        repeat (3) apply(idle());
`endif

        repeat (2) apply(idle());
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
